estacao_reserva_soma: RTL
=========================

Name: estacao_reserva_soma

Overview:
- Reservation station for the add/sub arithmetic unit (UA) of the Tomasulo core; sits directly upstream of the UA.
- Accepts issued instructions and holds them until both operands are present, capturing missing operands from the common data bus (CDB).
- Dispatches one ready entry per cycle to the combinational UA and registers the UA result.
- Presents the registered result as a CDB broadcast request, held until granted.

Parameters:
- N_ENT, 3, number of station entries (1..8).
- TAG_W, 3, tag width; tag value 0 is reserved and means "operand value present".
- DADO_W, 16, operand/result width.

Ports:
- Clock  in  1  system clock, rising edge.
- Resetn  in  1  asynchronous active-low reset.
- emite_valido  in  1  issue request.
- emite_pronto  out  1  station can accept an issue (at least one free entry).
- emite_op  in  3  operation code for UA (001 add, 010 sub).
- emite_tag  in  TAG_W  destination tag of the issued instruction (nonzero).
- emite_Vj, emite_Vk  in  DADO_W  operand values.
- emite_Qj, emite_Qk  in  TAG_W  producer tags; 0 = value already valid.
- cdb_valido  in  1  CDB broadcast valid.
- cdb_tag  in  TAG_W  tag on CDB.
- cdb_dado  in  DADO_W  value on CDB.
- Dado1, Dado2  out  DADO_W  operands driven to UA.
- op  out  3  opcode driven to UA; 000 when idle.
- Resultado  in  DADO_W  combinational UA result.
- res_valido  out  1  CDB broadcast request.
- res_tag  out  TAG_W  tag of held result.
- res_dado  out  DADO_W  held result.
- res_concedido  in  1  CDB grant; completes broadcast in the same cycle.

Behaviour:
- **Reset (Resetn=0, asynchronous):**
  - All entries free; emite_pronto=1.
  - res_valido=0, res_tag=0, res_dado=0.
  - op=000, Dado1=Dado2=0.
  - Reset mid-operation discards all entries and any held result.
- **Entry state:** LIVRE, ESPERA (Qj≠0 or Qk≠0), PRONTO (Qj=Qk=0). Fields per entry: op, tag, Vj, Vk, Qj, Qk.
- **Issue:**
  - An issue is accepted when emite_valido & emite_pronto; it writes the lowest-index LIVRE entry.
  - emite_valido while emite_pronto=0 is ignored (no state change). The source must hold the request.
  - emite_pronto is registered and reflects the state at the start of the cycle. An entry freed by dispatch this cycle is usable next cycle.
- **CDB capture:**
  - Every occupied entry with Qj==cdb_tag (Qj≠0) while cdb_valido=1 loads Vj←cdb_dado and Qj←0. Qk behaves identically and independently; both may be captured in the same cycle.
  - Issue-time bypass: if emite_Qj (or emite_Qk) equals cdb_tag with cdb_valido=1 in the issue cycle, the entry is written with the CDB value and Q=0.
- **Dispatch:**
  - Candidates are entries in PRONTO at the start of the cycle. An entry made ready by CDB this cycle dispatches no earlier than next cycle.
  - Priority: lowest index.
  - Dispatch occurs when a candidate exists and the result register is empty, or res_concedido=1 this cycle.
  - In the dispatch cycle, Dado1=Vj, Dado2=Vk, op=entry op (combinational from the selected entry).
  - At the clock edge: res_dado←Resultado, res_tag←entry tag, res_valido←1, entry←LIVRE.
  - When no dispatch occurs: op=000, Dado1=Dado2=0.
- **Latency:** issue with both operands valid at cycle t → dispatch at t+1 → res_valido=1 from t+2.
- **Result hold:**
  - res_valido, res_tag and res_dado stay stable until res_concedido=1, which clears res_valido at the edge unless a dispatch reloads it in the same cycle (back-to-back, no bubble).
  - res_concedido while res_valido=0 is ignored.
- **Arithmetic:** performed by UA; modulo 2^DADO_W. The station never inspects Resultado.
- **Own broadcast:** a granted result does not feed back into the station's own entries except via the external CDB inputs.

Test Plan:
1. Reset, issue add tag=1, Vj=5, Vk=7, Qj=Qk=0 → op=001, Dado1=5, Dado2=7 one cycle later; res_valido=1, res_tag=1, res_dado=12 after the next edge; hold 3 cycles without grant, then grant → res_valido=0.
2. Issue sub tag=2, Qj=4, Vk=3; two cycles later CDB tag=4, dado=10 → dispatch the cycle after capture; res_dado=7, res_tag=2.
3. Fill 3 entries all waiting on tag 5 → emite_pronto=0; a 4th issue is ignored. CDB tag=5, dado=1 → entries dispatch in index order 0, 1, 2 on consecutive cycles with the grant held high; no bubbles.
4. Issue with emite_Qj=6 in the same cycle as CDB tag=6, dado=9 → entry stores Vj=9, Qj=0 and dispatches next cycle.
5. Entry ready while a result is held and ungranted → no dispatch (op=000). Grant and dispatch happen in the same cycle → new result present next cycle, res_valido stays 1.
6. Assert Resetn low mid-dispatch with a result held → all outputs return to reset values immediately; emite_pronto=1.

Source files
------------

// File: rtl/estacao_reserva_soma.sv
// Reservation station for the add/sub unit: holds issued instructions until both
// operands arrive (directly or from the CDB), dispatches one per cycle and holds the result for the CDB.
module estacao_reserva_soma #(
    parameter int N_ENT  = 3,
    parameter int TAG_W  = 3,
    parameter int DADO_W = 16
) (
    input  logic              Clock,
    input  logic              Resetn,
    input  logic              emite_valido,
    output logic              emite_pronto,
    input  logic [2:0]        emite_op,
    input  logic [TAG_W-1:0]  emite_tag,
    input  logic [DADO_W-1:0] emite_Vj,
    input  logic [DADO_W-1:0] emite_Vk,
    input  logic [TAG_W-1:0]  emite_Qj,
    input  logic [TAG_W-1:0]  emite_Qk,
    input  logic              cdb_valido,
    input  logic [TAG_W-1:0]  cdb_tag,
    input  logic [DADO_W-1:0] cdb_dado,
    output logic [DADO_W-1:0] Dado1,
    output logic [DADO_W-1:0] Dado2,
    output logic [2:0]        op,
    input  logic [DADO_W-1:0] Resultado,
    output logic              res_valido,
    output logic [TAG_W-1:0]  res_tag,
    output logic [DADO_W-1:0] res_dado,
    input  logic              res_concedido
);
    localparam int IDX_W = (N_ENT > 1) ? $clog2(N_ENT) : 1;

    logic [N_ENT-1:0]  ocupado_reg, ocupado_next;
    logic [2:0]        op_reg  [N_ENT];
    logic [TAG_W-1:0]  tag_reg [N_ENT];
    logic [TAG_W-1:0]  qj_reg  [N_ENT];
    logic [TAG_W-1:0]  qk_reg  [N_ENT];
    logic [DADO_W-1:0] vj_reg  [N_ENT];
    logic [DADO_W-1:0] vk_reg  [N_ENT];

    logic              emite_pronto_reg;
    logic              res_valido_reg;
    logic [TAG_W-1:0]  res_tag_reg;
    logic [DADO_W-1:0] res_dado_reg;

    logic [N_ENT-1:0]  pronto, captura_j, captura_k;
    logic [IDX_W-1:0]  livre_idx, desp_idx;
    logic              tem_pronto, aceita, despacha;
    logic              bypass_j, bypass_k;
    logic [DADO_W-1:0] ins_vj, ins_vk;
    logic [TAG_W-1:0]  ins_qj, ins_qk;

    genvar gi;
    generate
        for (gi = 0; gi < N_ENT; gi++) begin : g_ent
            assign pronto[gi]    = ocupado_reg[gi] && (qj_reg[gi] == '0) && (qk_reg[gi] == '0);
            assign captura_j[gi] = ocupado_reg[gi] && cdb_valido && (qj_reg[gi] != '0) && (qj_reg[gi] == cdb_tag);
            assign captura_k[gi] = ocupado_reg[gi] && cdb_valido && (qk_reg[gi] != '0) && (qk_reg[gi] == cdb_tag);
        end
    endgenerate

    // Lowest-index free entry and lowest-index ready entry
    always_comb begin
        livre_idx  = '0;
        desp_idx   = '0;
        tem_pronto = 1'b0;
        for (int i = N_ENT - 1; i >= 0; i--) begin
            if (!ocupado_reg[i]) begin
                livre_idx = IDX_W'(i);
            end
            if (pronto[i]) begin
                desp_idx   = IDX_W'(i);
                tem_pronto = 1'b1;
            end
        end
    end

    assign aceita   = emite_valido && emite_pronto_reg;
    assign despacha = tem_pronto && (!res_valido_reg || res_concedido);

    // Operand forwarded straight from the CDB when its producer broadcasts during issue
    assign bypass_j = cdb_valido && (emite_Qj != '0) && (emite_Qj == cdb_tag);
    assign bypass_k = cdb_valido && (emite_Qk != '0) && (emite_Qk == cdb_tag);
    assign ins_vj   = bypass_j ? cdb_dado : emite_Vj;
    assign ins_vk   = bypass_k ? cdb_dado : emite_Vk;
    assign ins_qj   = bypass_j ? '0 : emite_Qj;
    assign ins_qk   = bypass_k ? '0 : emite_Qk;

    always_comb begin
        ocupado_next = ocupado_reg;
        if (despacha) begin
            ocupado_next[desp_idx] = 1'b0;
        end
        if (aceita) begin
            ocupado_next[livre_idx] = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            ocupado_reg      <= '0;
            emite_pronto_reg <= 1'b1;
            for (int i = 0; i < N_ENT; i++) begin
                op_reg[i]  <= '0;
                tag_reg[i] <= '0;
                vj_reg[i]  <= '0;
                vk_reg[i]  <= '0;
                qj_reg[i]  <= '0;
                qk_reg[i]  <= '0;
            end
        end else begin
            ocupado_reg      <= ocupado_next;
            emite_pronto_reg <= ~&ocupado_next;
            for (int i = 0; i < N_ENT; i++) begin
                if (aceita && (livre_idx == IDX_W'(i))) begin
                    op_reg[i]  <= emite_op;
                    tag_reg[i] <= emite_tag;
                    vj_reg[i]  <= ins_vj;
                    vk_reg[i]  <= ins_vk;
                    qj_reg[i]  <= ins_qj;
                    qk_reg[i]  <= ins_qk;
                end else begin
                    if (captura_j[i]) begin
                        vj_reg[i] <= cdb_dado;
                        qj_reg[i] <= '0;
                    end
                    if (captura_k[i]) begin
                        vk_reg[i] <= cdb_dado;
                        qk_reg[i] <= '0;
                    end
                end
            end
        end
    end

    // A dispatch reloads the result register even in the cycle its previous value is granted
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            res_valido_reg <= 1'b0;
            res_tag_reg    <= '0;
            res_dado_reg   <= '0;
        end else if (despacha) begin
            res_valido_reg <= 1'b1;
            res_tag_reg    <= tag_reg[desp_idx];
            res_dado_reg   <= Resultado;
        end else if (res_concedido) begin
            res_valido_reg <= 1'b0;
        end
    end

    always_comb begin
        op    = 3'b000;
        Dado1 = '0;
        Dado2 = '0;
        if (despacha) begin
            op    = op_reg[desp_idx];
            Dado1 = vj_reg[desp_idx];
            Dado2 = vk_reg[desp_idx];
        end
    end

    assign emite_pronto = emite_pronto_reg;
    assign res_valido   = res_valido_reg;
    assign res_tag      = res_tag_reg;
    assign res_dado     = res_dado_reg;

endmodule
